// File: rtl/gpu_pixel_lane_fifo_if.sv
// ---------------------------------------------------------------------------
// gpu_pixel_lane_fifo_if
//
// Purpose:
//   Bundles the write, pop, flush and status signals of the pixel lane FIFO
//   so the producer/consumer side and the FIFO itself connect through a
//   single port. Clock and reset are not part of the bundle.
//
// Parameters:
//   LANES        pixels per written word (2 or 4)
//   PIX_W        pixel width in bits
//   DEPTH_WIDTH  log2 of the number of stored words
//
// Signals:
//   i_write      write request for i_data
//   i_data       packed pixels, lane 0 in the low PIX_W bits
//   o_canWrite   at least one word slot is free
//   i_pop        0 none, 1 consume one pixel, 2 consume two, 3 none
//   o_pix0       oldest unread pixel
//   o_pix1       second-oldest unread pixel
//   o_pixCount   number of unread pixels stored
//   i_forceMask  force the top bit of o_pix0/o_pix1 high
//   i_flush      synchronous clear of contents and error flags
//   o_overflow   sticky: a write arrived while full
//   o_underflow  sticky: a pop asked for more pixels than stored
//
// Modports:
//   master  the side that writes words and pops pixels
//   slave   the FIFO
// ---------------------------------------------------------------------------
interface gpu_pixel_lane_fifo_if #(
   parameter int LANES       = 2,
   parameter int PIX_W       = 16,
   parameter int DEPTH_WIDTH = 4
);

   localparam int CNT_W = DEPTH_WIDTH + $clog2(LANES) + 1;

   logic                   i_write;
   logic [LANES*PIX_W-1:0] i_data;
   logic                   o_canWrite;
   logic [1:0]             i_pop;
   logic [PIX_W-1:0]       o_pix0;
   logic [PIX_W-1:0]       o_pix1;
   logic [CNT_W-1:0]       o_pixCount;
   logic                   i_forceMask;
   logic                   i_flush;
   logic                   o_overflow;
   logic                   o_underflow;

   modport master (
      output i_write,
      output i_data,
      input  o_canWrite,
      output i_pop,
      input  o_pix0,
      input  o_pix1,
      input  o_pixCount,
      output i_forceMask,
      output i_flush,
      input  o_overflow,
      input  o_underflow
   );

   modport slave (
      input  i_write,
      input  i_data,
      output o_canWrite,
      input  i_pop,
      output o_pix0,
      output o_pix1,
      output o_pixCount,
      input  i_forceMask,
      input  i_flush,
      output o_overflow,
      output o_underflow
   );

endinterface

// File: rtl/gpu_pixel_lane_fifo.sv
// ---------------------------------------------------------------------------
// gpu_pixel_lane_fifo
//
// Purpose:
//   Word-wide write, pixel-granular read FIFO. Producers push whole words of
//   LANES pixels; the consumer sees the two oldest unread pixels
//   first-word-fall-through and pops zero, one or two of them per cycle.
//   Errors (write while full, pop beyond stored pixels) are dropped and
//   latched in sticky flags until flush or reset.
//
// Parameters:
//   LANES        pixels per written word; only 2 and 4 are meaningful
//   PIX_W        pixel width in bits
//   DEPTH_WIDTH  storage holds 2^DEPTH_WIDTH words
//
// Ports:
//   i_clk        single clock, all state updates on its rising edge
//   i_nrst       asynchronous active-low reset
//   bus          gpu_pixel_lane_fifo_if slave modport carrying write data,
//                pop request, flush, force-mask and all status outputs
// ---------------------------------------------------------------------------
module gpu_pixel_lane_fifo #(
   parameter int LANES       = 2,
   parameter int PIX_W       = 16,
   parameter int DEPTH_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_nrst,
   gpu_pixel_lane_fifo_if.slave  bus
);

   localparam int DEPTH = 1 << DEPTH_WIDTH;
   localparam int LW    = $clog2(LANES);
   localparam int PW    = DEPTH_WIDTH + LW;
   localparam int CNT_W = PW + 1;
   localparam int WC_W  = DEPTH_WIDTH + 1;

   localparam logic [PIX_W-1:0] MSB_MASK = {1'b1, {(PIX_W-1){1'b0}}};

   // Storage is organised as words of lanes so the pixel pointer can index
   // it directly with its word and lane fields.
   logic [PIX_W-1:0] mem [DEPTH][LANES];

   // The read pointer is {word index, lane index}. Because LANES is a power
   // of two, a plain binary add wraps the lane into the word and the word
   // modulo the depth with no extra logic.
   logic [PW-1:0]          rd_ptr;
   logic [DEPTH_WIDTH-1:0] wr_ptr;
   logic [WC_W-1:0]        word_count;
   logic [CNT_W-1:0]       pix_count;
   logic                   overflow;
   logic                   underflow;

   logic [DEPTH_WIDTH-1:0] rd_word;
   logic [LW-1:0]          rd_lane;
   logic [PW-1:0]          nxt_ptr;
   logic [DEPTH_WIDTH-1:0] nxt_word;
   logic [LW-1:0]          nxt_lane;

   logic                   can_write;
   logic                   write_ok;
   logic                   write_drop;
   logic [CNT_W-1:0]       pop_num;
   logic                   pop_bad;
   logic [CNT_W-1:0]       pop_take;
   logic [LW:0]            lane_sum;
   logic                   word_free;
   logic [WC_W-1:0]        word_count_next;
   logic [CNT_W-1:0]       pix_count_next;
   logic [PW-1:0]          rd_ptr_next;

   // Write acceptance looks only at the registered word count, so a word
   // freed by a pop this cycle cannot be reused until the next cycle.
   assign can_write  = (word_count < WC_W'(DEPTH));
   assign write_ok   = bus.i_write & can_write;
   assign write_drop = bus.i_write & ~can_write;

   // Decode the pop request, reject it whole if it asks for more pixels than
   // are stored, and work out whether it consumes the last lane of the
   // current word (a pop of two can cross into the next word, but with at
   // least two lanes per word it never releases more than one).
   always_comb begin
      pop_num = '0;
      case (bus.i_pop)
         2'd1:    pop_num = CNT_W'(1);
         2'd2:    pop_num = CNT_W'(2);
         default: pop_num = '0;
      endcase

      pop_bad  = (pop_num > pix_count);
      pop_take = pop_bad ? '0 : pop_num;

      lane_sum  = {1'b0, rd_lane} + pop_take[LW:0];
      word_free = (lane_sum >= (LW+1)'(LANES));

      rd_ptr_next     = rd_ptr + pop_take[PW-1:0];
      word_count_next = word_count + WC_W'(write_ok) - WC_W'(word_free);
      pix_count_next  = pix_count + (write_ok ? CNT_W'(LANES) : '0) - pop_take;
   end

   // Pointer, count and flag registers. Flush wins over any write or pop in
   // the same cycle; the sticky flags only ever set outside of flush.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         word_count <= '0;
         pix_count  <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else if (bus.i_flush) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         word_count <= '0;
         pix_count  <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         rd_ptr     <= rd_ptr_next;
         wr_ptr     <= wr_ptr + DEPTH_WIDTH'(write_ok);
         word_count <= word_count_next;
         pix_count  <= pix_count_next;
         overflow   <= overflow | write_drop;
         underflow  <= underflow | pop_bad;
      end
   end

   // Storage has no reset; stale contents are never visible because the
   // counts say nothing is stored after reset or flush.
   always_ff @(posedge i_clk) begin
      if (write_ok && !bus.i_flush) begin
         for (int l = 0; l < LANES; l++) begin
            mem[wr_ptr][l] <= bus.i_data[l*PIX_W +: PIX_W];
         end
      end
   end

   // The second pixel is simply the one at pointer+1, which naturally moves
   // to lane 0 of the following word when the oldest pixel is a last lane.
   assign rd_word  = rd_ptr[PW-1:LW];
   assign rd_lane  = rd_ptr[LW-1:0];
   assign nxt_ptr  = rd_ptr + PW'(1);
   assign nxt_word = nxt_ptr[PW-1:LW];
   assign nxt_lane = nxt_ptr[LW-1:0];

   // The force mask only touches what leaves the block, never storage.
   assign bus.o_pix0 = mem[rd_word][rd_lane]   | (bus.i_forceMask ? MSB_MASK : '0);
   assign bus.o_pix1 = mem[nxt_word][nxt_lane] | (bus.i_forceMask ? MSB_MASK : '0);

   assign bus.o_canWrite  = can_write;
   assign bus.o_pixCount  = pix_count;
   assign bus.o_overflow  = overflow;
   assign bus.o_underflow = underflow;

endmodule
